// File: rtl/player_ctrl.sv
//------------------------------------------------------------------------------
// Module      : player_ctrl
// Description : Player sprite controller. Generates the movement tick and the
//               animation frame, walks the sprite around the stage under key
//               control (wall flags and screen bounds respected) and loads the
//               spawn point on every stage entry.
//               Optional build macro PLAYER_DIAG_EN enables independent
//               vertical/horizontal stepping (diagonal movement).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module player_ctrl #(
  parameter int MOVE_DIV = 1000000,
  parameter int ANIM_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic [3:0] blocked,
  output logic [8:0] player_x,
  output logic [8:0] player_y,
  output logic [3:0] player_state,
  output logic       moving
);

  localparam int c_tick_w = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int c_anim_w = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(MOVE_DIV - 1);
  localparam logic [c_anim_w-1:0] c_anim_last = c_anim_w'(ANIM_DIV - 1);

  // Facing codes as seen in the sprite frame index
  localparam logic [1:0] c_face_down  = 2'd0;
  localparam logic [1:0] c_face_up    = 2'd1;
  localparam logic [1:0] c_face_left  = 2'd2;
  localparam logic [1:0] c_face_right = 2'd3;

  // Game state codes of the three playable stages
  localparam logic [3:0] c_st_stage1 = 4'd2;
  localparam logic [3:0] c_st_stage2 = 4'd4;
  localparam logic [3:0] c_st_stage3 = 4'd6;

  // Sprite is 10x10 on a 320x240 field
  localparam logic [8:0] c_x_max = 9'd310;
  localparam logic [8:0] c_y_max = 9'd230;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WALK = 1'b1
  } fsm_t;

  fsm_t                fsm_q, fsm_d;
  logic [c_tick_w-1:0] tick_cnt_q, tick_cnt_d;
  logic [c_anim_w-1:0] anim_cnt_q, anim_cnt_d;
  logic                frame_q, frame_d;
  logic [1:0]          facing_q, facing_d;
  logic [8:0]          x_q, x_d;
  logic [8:0]          y_q, y_d;
  logic [3:0]          state_q, state_d;
  logic                moving_q, moving_d;

  logic in_stage, any_key, stage_entry, move_tick, anim_adv;
  logic v_up, v_dn, h_lf, h_rt;
  logic can_up, can_dn, can_lf, can_rt;
  logic [1:0] sel_face;

  // Next-state logic for counters, FSM, facing, frame and position
  always_comb begin
    in_stage    = (state == c_st_stage1) || (state == c_st_stage2) ||
                  (state == c_st_stage3);
    any_key     = key_up | key_down | key_left | key_right;
    stage_entry = in_stage && (state != state_q);
    move_tick   = (tick_cnt_q == c_tick_last);

`ifdef PLAYER_DIAG_EN
    // Each axis resolves its own priority; both may step on one tick
    v_up = key_up;
    v_dn = !key_up && key_down;
    h_lf = key_left;
    h_rt = !key_left && key_right;
`else
    // One direction only: up > down > left > right
    v_up = key_up;
    v_dn = !key_up && key_down;
    h_lf = !key_up && !key_down && key_left;
    h_rt = !key_up && !key_down && !key_left && key_right;
`endif

    // Vertical direction wins the facing when one is active
    if (v_up)      sel_face = c_face_up;
    else if (v_dn) sel_face = c_face_down;
    else if (h_lf) sel_face = c_face_left;
    else           sel_face = c_face_right;

    can_up = (y_q != 9'd0)   && !blocked[1];
    can_dn = (y_q <  c_y_max) && !blocked[0];
    can_lf = (x_q != 9'd0)   && !blocked[2];
    can_rt = (x_q <  c_x_max) && !blocked[3];

    tick_cnt_d = move_tick ? '0 : tick_cnt_q + 1'b1;
    anim_cnt_d = anim_cnt_q;
    frame_d    = frame_q;
    facing_d   = facing_q;
    x_d        = x_q;
    y_d        = y_q;
    state_d    = state;
    fsm_d      = (in_stage && any_key) ? WALK : IDLE;
    moving_d   = (fsm_d == WALK);
    anim_adv   = 1'b0;

    if (stage_entry) begin
      // Spawn load takes precedence over any step on this cycle
      tick_cnt_d = '0;
      anim_cnt_d = '0;
      frame_d    = 1'b0;
      facing_d   = c_face_down;
      y_d        = 9'd20;
      case (state)
        c_st_stage2: begin x_d = 9'd20;  y_d = 9'd200; end
        c_st_stage3: begin x_d = 9'd150; y_d = 9'd20;  end
        default:     begin x_d = 9'd20;  y_d = 9'd20;  end
      endcase
    end else if (!in_stage) begin
      // Menu screens: sprite faces down and keeps its idle animation
      facing_d = c_face_down;
      anim_adv = move_tick;
    end else if (!any_key) begin
      // Standing still in a stage shows frame 0
      anim_cnt_d = '0;
      frame_d    = 1'b0;
    end else begin
      facing_d = sel_face;
      if ((fsm_q == WALK) && move_tick) begin
        // Blocked or clamped steps still animate
        anim_adv = 1'b1;
        if (v_up && can_up)      y_d = y_q - 9'd1;
        else if (v_dn && can_dn) y_d = y_q + 9'd1;
        if (h_lf && can_lf)      x_d = x_q - 9'd1;
        else if (h_rt && can_rt) x_d = x_q + 9'd1;
      end
    end

    if (anim_adv) begin
      if (anim_cnt_q == c_anim_last) begin
        anim_cnt_d = '0;
        frame_d    = ~frame_q;
      end else begin
        anim_cnt_d = anim_cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset parks the sprite at the STAGE1 spawn point
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= IDLE;
      tick_cnt_q <= '0;
      anim_cnt_q <= '0;
      frame_q    <= 1'b0;
      facing_q   <= c_face_down;
      x_q        <= 9'd20;
      y_q        <= 9'd20;
      state_q    <= 4'd0;
      moving_q   <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      tick_cnt_q <= tick_cnt_d;
      anim_cnt_q <= anim_cnt_d;
      frame_q    <= frame_d;
      facing_q   <= facing_d;
      x_q        <= x_d;
      y_q        <= y_d;
      state_q    <= state_d;
      moving_q   <= moving_d;
    end
  end

  assign player_x     = x_q;
  assign player_y     = y_q;
  assign player_state = {1'b0, facing_q, frame_q};
  assign moving       = moving_q;

endmodule

`default_nettype wire

// File: tb/tb_player_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_player_ctrl
// Description : Directed self-checking bench for player_ctrl with
//               MOVE_DIV=4 and ANIM_DIV=2. Expectations that depend on the
//               PLAYER_DIAG_EN build option follow the same macro.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_player_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] state;
  logic       key_up, key_down, key_left, key_right;
  logic [3:0] blocked;
  logic [8:0] player_x, player_y;
  logic [3:0] player_state;
  logic       moving;

  int n_pass  = 0;
  int n_total = 0;

  // Frame index after ticks 1..8 of a fresh walk to the right
  int exp_ps [8] = '{6, 7, 7, 6, 6, 7, 7, 6};

`ifdef PLAYER_DIAG_EN
  localparam int c_x_diag1 = 27;
  localparam int c_x_diag2 = 26;
  localparam int c_ps_wall = 7;
  localparam int c_ps_menu1 = 1;
  localparam int c_ps_menu2 = 0;
`else
  localparam int c_x_diag1 = 28;
  localparam int c_x_diag2 = 28;
  localparam int c_ps_wall = 6;
  localparam int c_ps_menu1 = 0;
  localparam int c_ps_menu2 = 1;
`endif

  player_ctrl #(
    .MOVE_DIV (4),
    .ANIM_DIV (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .state        (state),
    .key_up       (key_up),
    .key_down     (key_down),
    .key_left     (key_left),
    .key_right    (key_right),
    .blocked      (blocked),
    .player_x     (player_x),
    .player_y     (player_y),
    .player_state (player_state),
    .moving       (moving)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; state = 4'd0; blocked = 4'd0;
    key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x", player_x, 20);
    chk("rst_y", player_y, 20);
    chk("rst_ps", player_state, 0);
    chk("rst_mv", moving, 0);

    // Enter STAGE1
    state = 4'd2; rst = 1'b0;
    step(1);
    chk("s1_x", player_x, 20);
    chk("s1_y", player_y, 20);
    chk("s1_ps", player_state, 0);
    chk("s1_mv", moving, 0);

    // Walk right for 8 ticks
    key_right = 1'b1;
    step(1);
    chk("wr_mv", moving, 1);
    chk("wr_face", player_state, 6);
    step(3);
    chk("wr_x1", player_x, 21);
    chk("wr_ps1", player_state, exp_ps[0]);
    for (int k = 2; k <= 8; k++) begin
      step(4);
      chk("wr_x", player_x, 20 + k);
      chk("wr_ps", player_state, exp_ps[k-1]);
    end
    key_right = 1'b0;
    step(1);
    chk("wr_rel_mv", moving, 0);
    chk("wr_rel_ps", player_state, 6);
    chk("wr_rel_x", player_x, 28);

    // Up against a wall: facing changes, position holds, frame animates
    key_up = 1'b1; blocked = 4'b0010;
    step(1);
    chk("bu_face", player_state, 2);
    chk("bu_mv", moving, 1);
    step(2);
    chk("bu_y1", player_y, 20);
    chk("bu_ps1", player_state, 2);
    step(4);
    chk("bu_ps2", player_state, 3);
    step(4);
    chk("bu_ps3", player_state, 3);
    step(4);
    chk("bu_ps4", player_state, 2);
    chk("bu_y4", player_y, 20);
    key_up = 1'b0; blocked = 4'd0;
    step(1);
    chk("bu_rel_mv", moving, 0);
    chk("bu_rel_ps", player_state, 2);

    // Up and left together
    key_up = 1'b1; key_left = 1'b1;
    step(1);
    chk("ul_face", player_state, 2);
    step(2);
    chk("ul_y1", player_y, 19);
    chk("ul_x1", player_x, c_x_diag1);
    step(4);
    chk("ul_y2", player_y, 18);
    chk("ul_x2", player_x, c_x_diag2);
    chk("ul_ps2", player_state, 3);
    key_up = 1'b0; key_left = 1'b0;
    step(1);
    chk("ul_rel_mv", moving, 0);

    // Walk right up to the right edge, then push into it
    key_right = 1'b1;
    for (int g = 0; g < 3000 && player_x !== 9'd309; g++) step(1);
    chk("edge_309", player_x, 309);
    step(4);
    chk("edge_x1", player_x, 310);
    chk("edge_f1", player_state[3:1], 3);
    step(4);
    chk("edge_x2", player_x, 310);
    chk("edge_f2", player_state[3:1], 3);
    step(4);
    chk("edge_x3", player_x, 310);
    chk("edge_ps3", player_state, c_ps_wall);
    chk("edge_y", player_y, 18);

    // SUCCESS1: face down, hold position, idle animation keeps running
    state = 4'd3; key_right = 1'b0;
    step(1);
    chk("m_mv", moving, 0);
    chk("m_ps1", player_state, c_ps_menu1);
    chk("m_x", player_x, 310);
    step(7);
    chk("m_ps2", player_state, c_ps_menu2);
    chk("m_y", player_y, 18);

    // STAGE2 entry loads its spawn point
    state = 4'd4;
    step(1);
    chk("s2_x", player_x, 20);
    chk("s2_y", player_y, 200);
    chk("s2_ps", player_state, 0);
    chk("s2_mv", moving, 0);
    key_up = 1'b1;
    step(1);
    chk("s2_face", player_state, 2);
    chk("s2_mv1", moving, 1);
    step(3);
    chk("s2_y1", player_y, 199);

    // Asynchronous reset in the middle of a walk
    @(posedge clk);
    #4;
    rst = 1'b1; state = 4'd3; key_up = 1'b0;
    #1;
    chk("ar_x", player_x, 20);
    chk("ar_y", player_y, 20);
    chk("ar_ps", player_state, 0);
    chk("ar_mv", moving, 0);

    // After release the first tick lands MOVE_DIV cycles later
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(7);
    chk("ar_ps7", player_state, 0);
    step(1);
    chk("ar_ps8", player_state, 1);
    chk("ar_x8", player_x, 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
